// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster generator: a free-running prescaler supplies the
// half-rate pixel advance, and the registered beam counters are decoded into sync/display flags.
module vga_timing_gen #(
    parameter int   CNT_WIDTH   = 24,
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 pix_tick,
    output logic [9:0]           hcount,
    output logic [9:0]           vcount,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 in_disp_area,
    output logic                 frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] H_FT     = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_FT     = 10'(V_VISIBLE - 1);

    logic [CNT_WIDTH-1:0] count_q,  count_d;
    logic [9:0]           hcount_q, hcount_d;
    logic [9:0]           vcount_q, vcount_d;

    always_comb begin
        count_d  = count_q + CNT_WIDTH'(1);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        // The >= tests also fold any unreachable out-of-range value back to 0.
        if (count_q[0]) begin
            if (hcount_q >= H_LAST) begin
                hcount_d = '0;
                if (vcount_q >= V_LAST) begin
                    vcount_d = '0;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            count_q  <= count_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // Pure decodes of the registered counters, so they move only on pixel advances.
    always_comb begin
        count        = count_q;
        pix_tick     = count_q[0];
        hcount       = hcount_q;
        vcount       = vcount_q;
        hsync        = (hcount_q >= HS_START && hcount_q < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync        = (vcount_q >= VS_START && vcount_q < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        in_disp_area = (hcount_q < H_VIS) && (vcount_q < V_VIS);
        frame_tick   = (hcount_q == H_FT) && (vcount_q == V_FT);
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a tiny-raster instance share
// clock and reset; every cycle is compared against beam position derived from elapsed clocks.
module tb_vga_timing_gen;

    localparam int   S_CW  = 4;
    localparam int   S_HV  = 8;
    localparam int   S_HF  = 2;
    localparam int   S_HS  = 2;
    localparam int   S_HB  = 2;
    localparam int   S_VV  = 6;
    localparam int   S_VF  = 1;
    localparam int   S_VS  = 2;
    localparam int   S_VB  = 1;
    localparam logic S_SA  = 1'b1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [23:0]   a_count;
    logic          a_pix_tick, a_hsync, a_vsync, a_in_disp, a_frame_tick;
    logic [9:0]    a_hcount, a_vcount;

    logic [S_CW-1:0] b_count;
    logic          b_pix_tick, b_hsync, b_vsync, b_in_disp, b_frame_tick;
    logic [9:0]    b_hcount, b_vcount;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint t        = 0;

    vga_timing_gen u_dut_a (
        .clock(clock), .reset(reset), .count(a_count), .pix_tick(a_pix_tick),
        .hcount(a_hcount), .vcount(a_vcount), .hsync(a_hsync), .vsync(a_vsync),
        .in_disp_area(a_in_disp), .frame_tick(a_frame_tick)
    );

    vga_timing_gen #(
        .CNT_WIDTH(S_CW), .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_ACTIVE(S_SA)
    ) u_dut_b (
        .clock(clock), .reset(reset), .count(b_count), .pix_tick(b_pix_tick),
        .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
        .in_disp_area(b_in_disp), .frame_tick(b_frame_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // Reference: after tt clock edges out of reset, tt/2 pixels have been emitted.
    task automatic check_raster(input string pfx, input longint tt, input int cw,
                                input int hv, input int hf, input int hs, input int hb,
                                input int vv, input int vf, input int vs, input int vb,
                                input logic sa, input logic [63:0] cnt, input logic pt,
                                input logic [9:0] hc, input logic [9:0] vc,
                                input logic hsy, input logic vsy, input logic ind,
                                input logic ft);
        longint p, ht, vt, h, v;
        logic [63:0] mask;
        p    = tt / 2;
        ht   = hv + hf + hs + hb;
        vt   = vv + vf + vs + vb;
        h    = p % ht;
        v    = (p / ht) % vt;
        mask = (64'd1 << cw) - 64'd1;
        check({pfx, "count"},    cnt, 64'(tt) & mask);
        check({pfx, "pix_tick"}, {63'd0, pt}, 64'(tt % 2));
        check({pfx, "hcount"},   {54'd0, hc}, 64'(h));
        check({pfx, "vcount"},   {54'd0, vc}, 64'(v));
        check({pfx, "hsync"},    {63'd0, hsy},
              {63'd0, (h >= hv + hf && h < hv + hf + hs) ? sa : ~sa});
        check({pfx, "vsync"},    {63'd0, vsy},
              {63'd0, (v >= vv + vf && v < vv + vf + vs) ? sa : ~sa});
        check({pfx, "in_disp"},  {63'd0, ind}, {63'd0, (h < hv && v < vv)});
        check({pfx, "frame_tick"}, {63'd0, ft}, {63'd0, (h == hv - 1 && v == vv - 1)});
    endtask

    task automatic check_all();
        check_raster("a_", t, 24, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                     {40'd0, a_count}, a_pix_tick, a_hcount, a_vcount,
                     a_hsync, a_vsync, a_in_disp, a_frame_tick);
        check_raster("b_", t, S_CW, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, S_SA,
                     {60'd0, b_count}, b_pix_tick, b_hcount, b_vcount,
                     b_hsync, b_vsync, b_in_disp, b_frame_tick);
    endtask

    task automatic step();
        @(posedge clock);
        t++;
        @(negedge clock);
        check_all();
    endtask

    // Reset lands between edges; outputs must already be cleared before any clock edge.
    task automatic async_reset();
        @(negedge clock);
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        t = 0;
        check_all();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        int hs_low, b_ft_cnt, b_vs_cnt, nseg, seglen;

        @(negedge clock);
        reset = 1'b0;
        t = 0;
        check_all();

        repeat (10) step();
        check("a_count_after10", {40'd0, a_count}, 64'd10);
        check("a_hcount_after10", {54'd0, a_hcount}, 64'd5);

        async_reset();
        hs_low = 0;
        b_ft_cnt = 0;
        b_vs_cnt = 0;
        for (int i = 1; i <= 1700; i++) begin
            step();
            if (t <= 1600 && a_hsync == 1'b0) hs_low++;
            if (t <= 280 && b_frame_tick) b_ft_cnt++;
            if (t <= 280 && b_vsync == S_SA) b_vs_cnt++;
            if (t == 16) check("b_count_wrap", {60'd0, b_count}, 64'd0);
            if (t == 1600) begin
                check("a_line_wrap_h", {54'd0, a_hcount}, 64'd0);
                check("a_line_wrap_v", {54'd0, a_vcount}, 64'd1);
            end
            if (t == 280) begin
                check("b_frame_wrap_h", {54'd0, b_hcount}, 64'd0);
                check("b_frame_wrap_v", {54'd0, b_vcount}, 64'd0);
            end
        end
        check("a_hsync_low_clocks", 64'(hs_low), 64'd192);
        check("b_frame_tick_clocks", 64'(b_ft_cnt), 64'd2);
        check("b_vsync_active_clocks", 64'(b_vs_cnt), 64'd56);

        nseg = 6;
        for (int s = 0; s < nseg; s++) begin
            seglen = $urandom_range(20, 2500);
            for (int i = 0; i < seglen; i++) step();
            async_reset();
        end
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Produces the 640x480@60 Hz VGA raster timing for the game display.
- Combines two functions in one block:
  - a free-running prescaler counter that derives the pixel rate from the board clock;
  - a horizontal/vertical sync generator that outputs beam coordinates, sync pulses, a display-area flag and an end-of-visible-frame strobe.
- Sits between the board clock and the game/render logic.
- Downstream logic consumes `hcount`/`vcount` and updates game state on `frame_tick`.

## Interface
- `CNT_WIDTH`, default 24: width of the prescaler counter.
- `H_VISIBLE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync pulse width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_VISIBLE`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync pulse width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.
- `SYNC_ACTIVE`, default 1'b0: level of hsync/vsync during the pulse.
- `clock`  in  1: board clock (50 MHz nominal). One clock; reset is asynchronous and active-high.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `count`  out  CNT_WIDTH: free-running prescaler value; `count[0]` is the half-rate pixel clock.
- `pix_tick`  out  1: high on clock cycles where `count[0]==1`, i.e. the pixel-advance cycle.
- `hcount`  out  10: current pixel column, 0..799.
- `vcount`  out  10: current line, 0..524.
- `hsync`  out  1: horizontal sync.
- `vsync`  out  1: vertical sync.
- `in_disp_area`  out  1: beam is inside the visible 640x480 area.
- `frame_tick`  out  1: high while `hcount==639 && vcount==479`, the last visible pixel.

## Operation
- **Prescaler:** `count` increments by 1 on every `clock` rising edge and wraps from all-ones to 0. It has no enable.
- **Pixel advance:** `hcount`/`vcount` update only on edges where `pix_tick==1`. That gives one pixel every 2 clocks (25 MHz from 50 MHz).
- **Horizontal total:** `H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP` = 800.
- **Vertical total:** `V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP` = 525.
- **Horizontal counter:** on a pixel advance, if `hcount==H_TOTAL-1`, `hcount` goes to 0 and `vcount` advances; otherwise `hcount+1`.
- **Vertical counter:** `vcount` advances only at the horizontal wrap. If `vcount==V_TOTAL-1` it goes to 0, otherwise `vcount+1`. The simultaneous wrap at (799,524) yields (0,0).
- **hsync:** equals `SYNC_ACTIVE` when `H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC` (656..751); otherwise `~SYNC_ACTIVE`.
- **vsync:** equals `SYNC_ACTIVE` when `V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC` (490..491); otherwise `~SYNC_ACTIVE`.
- **in_disp_area:** `hcount<H_VISIBLE && vcount<V_VISIBLE`.
- **frame_tick:** decoded combinationally from the counters. It stays high for the full pixel period at (639,479), i.e. 2 clocks.
- **Arithmetic:** comparisons are unsigned. Counters never exceed their total minus 1. Any out-of-range value, which is unreachable, wraps to 0 on the next advance.

## Timing
- **Reset values:** `count=0`, `hcount=0`, `vcount=0`. Therefore `hsync=vsync=~SYNC_ACTIVE` (1), `in_disp_area=1`, `frame_tick=0`, `pix_tick=0`.
- **Reset assertion:** asynchronous; outputs reach their reset values without waiting for a clock edge. Asserting it mid-line or mid-frame restarts the raster at (0,0) with `count=0`.
- **Reset release:** synchronous to `clock` in use.
  - First edge after release: `count` goes 0→1, no pixel advance.
  - Second edge: `pix_tick` is high, so `hcount` goes to 1.
- **Output latency:** `hsync`, `vsync`, `in_disp_area` and `frame_tick` have zero latency relative to `hcount`/`vcount`; they are pure decodes of registered counters.
  - They change only on pixel-advance edges.
  - The registered counters guarantee glitch-free sync if outputs are registered externally.
- **Line period:** 1600 clocks.
- **Frame period:** 840000 clocks.
- **hsync pulse:** 192 clocks.
- **vsync pulse:** 3200 clocks.

## Test plan
- **Reset:** assert `reset` mid-frame without a clock edge → `count`, `hcount`, `vcount` read 0 immediately; `hsync=vsync=1`; `in_disp_area=1`.
- **Prescaler/pixel rate:** release reset and run 10 clocks → `count=10`; `hcount=5`; `pix_tick` alternates 0,1,0,1…
- **Horizontal timing:** run one line from (0,0) → `hsync` falls when `hcount` becomes 656 and rises at 752. `in_disp_area` falls at `hcount=640`. `hcount` wraps 799→0 while `vcount` goes 0→1 at clock 1600.
- **Vertical timing and frame strobe:** run a full frame → `vsync` is low only for `vcount` 490–491 (3200 clocks). `frame_tick` is high for exactly 2 clocks at (639,479). `vcount` wraps 524→0 with `hcount` 799→0 after 840000 clocks.
- **Counter wrap:** force-run with `CNT_WIDTH=4` → `count` goes 15→0 and the pixel cadence continues without a skipped or doubled advance.
- **Parameter override:** `SYNC_ACTIVE=1`, `H_VISIBLE=8`, `H_FP=H_SYNC=H_BP=2` → `hcount` wraps at 13, `hsync` is high for `hcount` 10–11 only.
